// File: rtl/stage_mem_pkg.sv
// rtl/stage_mem_pkg.sv - shared opcodes, FSM state encodings and reset level for the MEM stage
package stage_mem_pkg;

    localparam logic RESET_ACTIVE = 1'b0;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;

    // Memory operators occupy 0x20..0x27 so the category is a single 5-bit compare
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h25;
    localparam logic [7:0] OP_SH  = 8'h26;
    localparam logic [7:0] OP_SW  = 8'h27;

    localparam logic [4:0] CATEGORY_MEMORY = 5'b00100;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_WAIT = 2'd1,
        MEM_STATE_DONE = 2'd2
    } mem_state_t;

    function automatic logic op_is_memory(input logic [7:0] op);
        return op[7:3] == CATEGORY_MEMORY;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane select, store replication, load extension and alignment check
module mem_lane_align
    import stage_mem_pkg::*;
(
    input  logic [7:0]  operator,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_select,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        is_store,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = read_data[7:0];
        case (offset)
            2'd1:    lane_byte = read_data[15:8];
            2'd2:    lane_byte = read_data[23:16];
            2'd3:    lane_byte = read_data[31:24];
            default: lane_byte = read_data[7:0];
        endcase
        lane_half = offset[1] ? read_data[31:16] : read_data[15:0];
    end

    always_comb begin
        byte_select = 4'b0000;
        write_data  = 32'h0;
        load_data   = 32'h0;
        is_store    = 1'b0;
        misaligned  = 1'b0;
        case (operator)
            OP_LB: begin
                byte_select = 4'b0001 << offset;
                load_data   = {{24{lane_byte[7]}}, lane_byte};
            end
            OP_LBU: begin
                byte_select = 4'b0001 << offset;
                load_data   = {24'h0, lane_byte};
            end
            OP_SB: begin
                byte_select = 4'b0001 << offset;
                write_data  = {4{store_data[7:0]}};
                is_store    = 1'b1;
            end
            OP_LH: begin
                byte_select = offset[1] ? 4'b1100 : 4'b0011;
                load_data   = {{16{lane_half[15]}}, lane_half};
                misaligned  = offset[0];
            end
            OP_LHU: begin
                byte_select = offset[1] ? 4'b1100 : 4'b0011;
                load_data   = {16'h0, lane_half};
                misaligned  = offset[0];
            end
            OP_SH: begin
                byte_select = offset[1] ? 4'b1100 : 4'b0011;
                write_data  = {2{store_data[15:0]}};
                is_store    = 1'b1;
                misaligned  = offset[0];
            end
            OP_LW: begin
                byte_select = 4'b1111;
                load_data   = read_data;
                misaligned  = |offset;
            end
            OP_SW: begin
                byte_select = 4'b1111;
                write_data  = store_data;
                is_store    = 1'b1;
                misaligned  = |offset;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - MIPS MEM stage with request/ack data bus FSM; optional MEM_BUS_TIMEOUT_EN
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction_i,
    input  logic [7:0]  operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        reg_write_enable_i,
    input  logic [4:0]  reg_write_address_i,
    input  logic [31:0] reg_write_data_i,
    output logic        reg_write_enable_o,
    output logic [4:0]  reg_write_address_o,
    output logic [31:0] reg_write_data_o,
    output logic        mem_request,
    output logic        mem_write_enable,
    output logic [3:0]  mem_byte_select,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack,
    output logic        address_error,
    output logic        bus_error,
    output logic        stall_request
);

    mem_state_t  state, next_state;
    logic [31:0] addr;
    logic [31:0] capture_q;
    logic [31:0] lane_write_data, lane_load_data;
    logic [3:0]  lane_byte_select;
    logic        is_memory, is_store, misaligned, issue, capture_en;
    logic        timeout_hit, timed_out, request;
    logic        unused_instr_bits;

    assign addr              = operand_a_i + {{16{instruction_i[15]}}, instruction_i[15:0]};
    assign unused_instr_bits = ^instruction_i[31:16];
    assign is_memory         = op_is_memory(operator_i);
    assign issue             = is_memory && !misaligned;

    mem_lane_align u_lane_align (
        .operator    (operator_i),
        .offset      (addr[1:0]),
        .store_data  (operand_b_i),
        .read_data   (mem_read_data),
        .byte_select (lane_byte_select),
        .write_data  (lane_write_data),
        .load_data   (lane_load_data),
        .is_store    (is_store),
        .misaligned  (misaligned)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_count;

    // Ack on the limit edge keeps priority, so the hit is qualified with !mem_ack
    assign timeout_hit = (state == MEM_STATE_WAIT) && !mem_ack &&
                         (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            wait_count <= '0;
            timed_out  <= 1'b0;
        end else begin
            wait_count <= (state == MEM_STATE_WAIT) ? wait_count + 1'b1 : '0;
            timed_out  <= timeout_hit;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign timed_out      = 1'b0;
`endif

    assign capture_en = mem_ack && (((state == MEM_STATE_IDLE) && issue) || (state == MEM_STATE_WAIT));

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            state     <= MEM_STATE_IDLE;
            capture_q <= 32'h0;
        end else begin
            state <= next_state;
            if (capture_en) begin
                capture_q <= lane_load_data;
            end
        end
    end

    always_comb begin
        next_state          = state;
        request             = 1'b0;
        mem_request         = 1'b0;
        mem_write_enable    = 1'b0;
        mem_byte_select     = 4'b0000;
        mem_address         = 32'h0;
        mem_write_data      = 32'h0;
        stall_request       = 1'b0;
        address_error       = 1'b0;
        bus_error           = 1'b0;
        reg_write_enable_o  = reg_write_enable_i;
        reg_write_address_o = reg_write_address_i;
        reg_write_data_o    = reg_write_data_i;
        case (state)
            MEM_STATE_IDLE: begin
                if (issue) begin
                    request    = 1'b1;
                    next_state = mem_ack ? MEM_STATE_DONE : MEM_STATE_WAIT;
                end else if (is_memory) begin
                    address_error      = 1'b1;
                    reg_write_enable_o = 1'b0;
                end
            end
            MEM_STATE_WAIT: begin
                request = 1'b1;
                if (mem_ack || timeout_hit) begin
                    next_state = MEM_STATE_DONE;
                end
            end
            MEM_STATE_DONE: begin
                next_state = MEM_STATE_IDLE;
                bus_error  = timed_out;
                if (is_store || timed_out) begin
                    reg_write_enable_o = 1'b0;
                end else begin
                    reg_write_data_o = capture_q;
                end
            end
            default: next_state = MEM_STATE_IDLE;
        endcase
        // Inputs are held upstream while stalled, so bus fields can come straight from them
        if (request) begin
            mem_request        = 1'b1;
            stall_request      = 1'b1;
            mem_write_enable   = is_store;
            mem_byte_select    = lane_byte_select;
            mem_address        = {addr[31:2], 2'b00};
            mem_write_data     = lane_write_data;
            reg_write_enable_o = 1'b0;
        end
        if (reset == RESET_ACTIVE) begin
            mem_request         = 1'b0;
            mem_write_enable    = 1'b0;
            mem_byte_select     = 4'b0000;
            mem_address         = 32'h0;
            mem_write_data      = 32'h0;
            stall_request       = 1'b0;
            address_error       = 1'b0;
            bus_error           = 1'b0;
            reg_write_enable_o  = 1'b0;
            reg_write_address_o = 5'h0;
            reg_write_data_o    = 32'h0;
        end
    end

endmodule
